wb_arbiter: RTL and testbench

//  Shares the single GPR/FPR register-file write port (write_reg/write_data/reg_write_i/FPR_GPR_sel of decode)

---
 rtl/wb_arbiter.sv | 117 +++++++++++
 tb/tb_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin arbiter for the shared GPR/FPR write port, with a registered write port
// and a 32+32 busy scoreboard that flags RAW hazards to decode.
module wb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [5*N_REQ-1:0]      req_rd,
  input  logic [N_REQ-1:0]        req_fpr,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_fpr,
  input  logic [4:0]              chk_rs1,
  input  logic [4:0]              chk_rs2,
  input  logic                    chk_fpr1,
  input  logic                    chk_fpr2,
  output logic                    hazard,
  output logic                    reg_write,
  output logic [4:0]              write_reg,
  output logic [DATA_W-1:0]       write_data,
  output logic                    FPR_GPR_sel
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     grant_idx;
  logic [PW:0]       cand;
  logic [N_REQ-1:0]  grant;
  logic              any_grant;
  logic [4:0]        sel_rd;
  logic              sel_fpr;
  logic [DATA_W-1:0] sel_data;
  logic [31:0]       busy_gpr;
  logic [31:0]       busy_fpr;
  logic              busy1;
  logic              busy2;

  // Handshake: a source holds req_valid with stable rd/fpr/data until req_ready;
  // the result transfers on the rising edge where both are high.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    sel_rd    = '0;
    sel_fpr   = 1'b0;
    sel_data  = '0;
    if (rst) begin
      // Search starts at ptr and wraps; the first valid requester wins.
      for (int k = 0; k < N_REQ; k++) begin
        cand = {1'b0, ptr} + (PW+1)'(k);
        if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
        if (!any_grant && req_valid[cand[PW-1:0]]) begin
          any_grant               = 1'b1;
          grant[cand[PW-1:0]]     = 1'b1;
          grant_idx               = cand[PW-1:0];
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = req_rd[5*i +: 5];
        sel_fpr  = req_fpr[i];
        sel_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      reg_write   <= 1'b0;
      write_reg   <= '0;
      write_data  <= '0;
      FPR_GPR_sel <= 1'b0;
    end else if (any_grant) begin
      // GPR x0 results are consumed but never written back.
      reg_write   <= sel_fpr | (sel_rd != 5'd0);
      write_reg   <= sel_rd;
      write_data  <= sel_data;
      FPR_GPR_sel <= sel_fpr;
      if (grant_idx == PW'(N_REQ-1)) ptr <= '0;
      else                           ptr <= grant_idx + 1'b1;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // The set is written after the clear so a newer in-flight writer keeps the bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_gpr <= '0;
      busy_fpr <= '0;
    end else begin
      if (reg_write) begin
        if (FPR_GPR_sel) busy_fpr[write_reg] <= 1'b0;
        else             busy_gpr[write_reg] <= 1'b0;
      end
      if (issue_valid) begin
        if (issue_fpr)               busy_fpr[issue_rd] <= 1'b1;
        else if (issue_rd != 5'd0)   busy_gpr[issue_rd] <= 1'b1;
      end
    end
  end

  assign busy1  = chk_fpr1 ? busy_fpr[chk_rs1] : busy_gpr[chk_rs1];
  assign busy2  = chk_fpr2 ? busy_fpr[chk_rs2] : busy_gpr[chk_rs2];
  assign hazard = rst & (busy1 | busy2);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single grant, round-robin order, x0 drop,
// scoreboard set/clear and set/clear collision.
module tb_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [19:0]  req_rd;
  logic [3:0]   req_fpr;
  logic [127:0] req_data;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic         issue_fpr;
  logic [4:0]   chk_rs1;
  logic [4:0]   chk_rs2;
  logic         chk_fpr1;
  logic         chk_fpr2;
  logic         hazard;
  logic         reg_write;
  logic [4:0]   write_reg;
  logic [31:0]  write_data;
  logic         FPR_GPR_sel;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.N_REQ(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_fpr(req_fpr), .req_data(req_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_fpr(issue_fpr),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_fpr1(chk_fpr1), .chk_fpr2(chk_fpr2),
    .hazard(hazard), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .FPR_GPR_sel(FPR_GPR_sel)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_valid   = '0;
    req_rd      = '0;
    req_fpr     = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_fpr   = 1'b0;
    chk_rs1     = '0;
    chk_rs2     = '0;
    chk_fpr1    = 1'b0;
    chk_fpr2    = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  // driver
  task automatic set_req(input int i, input logic v, input logic [4:0] rd,
                         input logic fpr, input logic [31:0] d);
    req_valid[i]        = v;
    req_rd[5*i +: 5]    = rd;
    req_fpr[i]          = fpr;
    req_data[32*i +: 32] = d;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_inputs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(8 + i), 1'b0, 32'hC000_0000 + 32'(i));
    tick();
    tick();
    n_cmp++;
    if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_cmp++;
    if (reg_write !== 1'b0) begin n_err++; $display("FAIL reset_reg_write: got %b expected 0", reg_write); end
    n_cmp++;
    if (hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard: got %b expected 0", hazard); end
    n_cmp++;
    if (write_data !== 32'h0 || write_reg !== 5'd0 || FPR_GPR_sel !== 1'b0) begin
      n_err++; $display("FAIL reset_port: got reg %0d data %h sel %b expected 0/0/0", write_reg, write_data, FPR_GPR_sel);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++;
    if (reg_write !== 1'b1 || write_reg !== 5'd8 || write_data !== 32'hC000_0000) begin
      n_err++; $display("FAIL reset_first_write: got we %b reg %0d data %h expected 1/8/c0000000", reg_write, write_reg, write_data);
    end
  endtask

  task automatic test_single;
    do_reset();
    set_req(2, 1'b1, 5'd5, 1'b0, 32'hDEADBEEF);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++;
    if (reg_write !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEADBEEF || FPR_GPR_sel !== 1'b0) begin
      n_err++; $display("FAIL single_write: got we %b reg %0d data %h sel %b expected 1/5/deadbeef/0",
                        reg_write, write_reg, write_data, FPR_GPR_sel);
    end
    tick();
    n_cmp++;
    if (reg_write !== 1'b0 || write_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_idle_hold: got we %b data %h expected 0/deadbeef", reg_write, write_data);
    end
  endtask

  task automatic test_round_robin;
    int exp_i;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(10 + i), 1'b0, 32'hA000_0000 + 32'(i));
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_i = k % 4;
      n_cmp++;
      if (req_ready !== 4'(1 << exp_i)) begin
        n_err++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, 4'(1 << exp_i));
      end
      tick();
      n_cmp++;
      if (reg_write !== 1'b1 || write_reg !== 5'(10 + exp_i) || write_data !== 32'hA000_0000 + 32'(exp_i)) begin
        n_err++; $display("FAIL rr_write_%0d: got we %b reg %0d data %h expected 1/%0d/%h",
                          k, reg_write, write_reg, write_data, 10 + exp_i, 32'hA000_0000 + 32'(exp_i));
      end
    end
    req_valid = '0;
  endtask

  task automatic test_x0;
    do_reset();
    set_req(0, 1'b1, 5'd0, 1'b0, 32'h0BAD_0BAD);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL x0_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++;
    if (reg_write !== 1'b0) begin n_err++; $display("FAIL x0_dropped: got %b expected 0", reg_write); end
    set_req(0, 1'b1, 5'd0, 1'b1, 32'h1234_5678);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL f0_ready_wrap: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++;
    if (reg_write !== 1'b1 || write_reg !== 5'd0 || FPR_GPR_sel !== 1'b1 || write_data !== 32'h1234_5678) begin
      n_err++; $display("FAIL f0_write: got we %b reg %0d sel %b data %h expected 1/0/1/12345678",
                        reg_write, write_reg, FPR_GPR_sel, write_data);
    end
  endtask

  task automatic test_scoreboard;
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd7; issue_fpr = 1'b1;
    chk_rs1 = 5'd7; chk_fpr1 = 1'b1;
    #1;
    n_cmp++;
    if (hazard !== 1'b0) begin n_err++; $display("FAIL sb_before_set: got %b expected 0", hazard); end
    tick();
    issue_valid = 1'b0;
    #1;
    n_cmp++;
    if (hazard !== 1'b1) begin n_err++; $display("FAIL sb_f7_busy: got %b expected 1", hazard); end
    chk_fpr1 = 1'b0;
    #1;
    n_cmp++;
    if (hazard !== 1'b0) begin n_err++; $display("FAIL sb_x7_clear: got %b expected 0", hazard); end
    chk_rs1 = 5'd0; chk_rs2 = 5'd7; chk_fpr2 = 1'b1;
    #1;
    n_cmp++;
    if (hazard !== 1'b1) begin n_err++; $display("FAIL sb_f7_rs2: got %b expected 1", hazard); end
    set_req(3, 1'b1, 5'd7, 1'b1, 32'hF7F7_F7F7);
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin n_err++; $display("FAIL sb_fpu_ready: got %b expected 1000", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++;
    if (reg_write !== 1'b1 || hazard !== 1'b1) begin
      n_err++; $display("FAIL sb_write_cycle: got we %b hazard %b expected 1/1", reg_write, hazard);
    end
    tick();
    n_cmp++;
    if (hazard !== 1'b0) begin n_err++; $display("FAIL sb_after_write: got %b expected 0", hazard); end
    issue_valid = 1'b1; issue_rd = 5'd0; issue_fpr = 1'b0;
    chk_rs1 = 5'd0; chk_fpr1 = 1'b0; chk_rs2 = 5'd0; chk_fpr2 = 1'b0;
    tick();
    issue_valid = 1'b0;
    n_cmp++;
    if (hazard !== 1'b0) begin n_err++; $display("FAIL sb_x0_never_busy: got %b expected 0", hazard); end
  endtask

  task automatic test_collide;
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd3; issue_fpr = 1'b0;
    tick();
    issue_valid = 1'b0;
    set_req(1, 1'b1, 5'd3, 1'b0, 32'h3333_3333);
    tick();
    req_valid = '0;
    issue_valid = 1'b1; issue_rd = 5'd3; issue_fpr = 1'b0;
    chk_rs1 = 5'd3; chk_fpr1 = 1'b0;
    #1;
    n_cmp++;
    if (reg_write !== 1'b1 || write_reg !== 5'd3 || hazard !== 1'b1) begin
      n_err++; $display("FAIL collide_write_cycle: got we %b reg %0d hazard %b expected 1/3/1", reg_write, write_reg, hazard);
    end
    tick();
    issue_valid = 1'b0;
    #1;
    n_cmp++;
    if (hazard !== 1'b1) begin n_err++; $display("FAIL collide_set_wins: got %b expected 1", hazard); end
    tick();
    n_cmp++;
    if (hazard !== 1'b1) begin n_err++; $display("FAIL collide_still_busy: got %b expected 1", hazard); end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_scoreboard();
    test_collide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
